// File: rtl/l2_host_req_arb.sv
// rtl/l2_host_req_arb.sv - round-robin host request arbiter with in-order tagged response write-back
module l2_host_req_arb #(
    parameter int nstrm            = 8,
    parameter int addr_width       = 64,
    parameter int cache_line       = 128,
    parameter int l2_ncl           = 256,
    parameter int max_out          = 32,
    parameter int cache_line_width = $clog2(cache_line),
    parameter int l2_ncl_width     = $clog2(l2_ncl),
    parameter int tag_width        = $clog2(max_out),
    parameter int strm_width       = $clog2(nstrm)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [nstrm-1:0]            i_req_v,
    output logic [nstrm-1:0]            i_req_r,
    input  logic [nstrm*addr_width-1:0] i_req_ea,
    output logic                        o_req_v,
    input  logic                        o_req_r,
    output logic [addr_width-1:0]       o_req_ea,
    output logic [tag_width-1:0]        o_req_tag,
    input  logic                        i_rsp_v,
    output logic                        i_rsp_r,
    input  logic [tag_width-1:0]        i_rsp_tag,
    input  logic [cache_line*8-1:0]     i_rsp_data,
    output logic                        o_wr_v,
    input  logic                        o_wr_r,
    output logic [strm_width-1:0]       o_wr_strm,
    output logic [l2_ncl_width-1:0]     o_wr_ptr,
    output logic [cache_line*8-1:0]     o_wr_data,
    output logic [nstrm-1:0]            o_rsp_v,
    output logic                        o_err
);

    localparam int                    ent_width = strm_width + l2_ncl_width;
    localparam logic [tag_width:0]    max_cnt   = (tag_width+1)'(max_out);
    localparam logic [strm_width-1:0] last_strm = strm_width'(nstrm - 1);
    localparam logic [strm_width:0]   nstrm_w   = (strm_width+1)'(nstrm);

    logic                    rdy_en;
    logic [strm_width-1:0]   rr;
    logic [strm_width-1:0]   win;
    logic                    found;
    logic [strm_width:0]     idx;
    logic [tag_width-1:0]    head;
    logic [tag_width-1:0]    tail;
    logic [tag_width:0]      count;
    logic [ent_width-1:0]    tag_tbl [max_out];
    logic [addr_width-1:0]   req_ea [nstrm];
    logic [ent_width-1:0]    head_ent;
    logic                    grant;
    logic                    rsp_acc;
    logic                    rsp_ok;

    for (genvar g = 0; g < nstrm; g++) begin : g_ea
        assign req_ea[g] = i_req_ea[g*addr_width +: addr_width];
    end

    // First valid stream at or after the RR pointer, wrapping modulo nstrm.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < nstrm; i++) begin
            idx = {1'b0, rr} + (strm_width+1)'(i);
            if (idx >= nstrm_w) idx = idx - nstrm_w;
            if (!found && i_req_v[idx[strm_width-1:0]]) begin
                found = 1'b1;
                win   = idx[strm_width-1:0];
            end
        end
    end

    assign grant = ~reset & rdy_en & found & (~o_req_v | o_req_r) & (count < max_cnt);

    always_comb begin
        i_req_r = '0;
        if (grant) i_req_r[win] = 1'b1;
    end

    assign i_rsp_r  = ~o_wr_v | o_wr_r;
    assign rsp_acc  = i_rsp_v & i_rsp_r;
    assign rsp_ok   = rsp_acc & (count != '0) & (i_rsp_tag == head);
    assign head_ent = tag_tbl[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_en  <= 1'b0;
            rr      <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            o_req_v <= 1'b0;
            o_wr_v  <= 1'b0;
            o_rsp_v <= '0;
            o_err   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (grant) begin
                o_req_v <= 1'b1;
                tail    <= tail + 1'b1;
                rr      <= (win == last_strm) ? '0 : win + 1'b1;
            end else if (o_req_r) begin
                o_req_v <= 1'b0;
            end
            if (rsp_ok) begin
                o_wr_v <= 1'b1;
                head   <= head + 1'b1;
            end else if (o_wr_r) begin
                o_wr_v <= 1'b0;
            end
            if (rsp_acc && !rsp_ok) o_err <= 1'b1;
            if (grant && !rsp_ok)      count <= count + 1'b1;
            else if (!grant && rsp_ok) count <= count - 1'b1;
            // Notify only after the URAM write has been accepted.
            o_rsp_v <= '0;
            if (o_wr_v && o_wr_r) o_rsp_v[o_wr_strm] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            o_req_ea      <= req_ea[win];
            o_req_tag     <= tail;
            tag_tbl[tail] <= {win, req_ea[win][cache_line_width +: l2_ncl_width]};
        end
        if (rsp_ok) begin
            {o_wr_strm, o_wr_ptr} <= head_ent;
            o_wr_data             <= i_rsp_data;
        end
    end

endmodule
